// File: rtl/datapath_pkg.sv
// Shared widths and ALU operation codes for the datapath core.
package datapath_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DWORD_W  = 64;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ALUOP_W  = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [DWORD_W-1:0] dword_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_SHR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SHRA = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SHL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_ROR  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_ROL  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_NEG  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_NOT  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_MUL  = 4'd11;
  localparam logic [ALUOP_W-1:0] ALU_INC  = 4'd12;

endpackage

// File: rtl/datapath_core_alu.sv
// Combinational ALU: logic/shift ops, Booth multiplier, optional divider.
// Build option: DATAPATH_DIV_EN compiles in the signed divider; without it
// a divide request returns zero.
module alu
  import datapath_pkg::*;
(
  input  logic [WORD_W-1:0]  a,
  input  logic [WORD_W-1:0]  b,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic               alu_div,
  output logic [DWORD_W-1:0] result_c
);

  logic [SHAMT_W-1:0] sh;
  dword_t             mul_p;
  dword_t             ror_w;
  dword_t             rol_w;
  word_t              res_hi;
  word_t              res_lo;

  assign sh    = b[SHAMT_W-1:0];
  assign ror_w = {a, a} >> sh;
  assign rol_w = {a, a} << sh;

  // Radix-2 Booth recoding of b, accumulating sign-extended partial products of a
  always_comb begin : booth_mul
    dword_t a_ext;
    dword_t acc;
    logic   prev;
    a_ext = DWORD_W'($signed(a));
    acc   = '0;
    prev  = 1'b0;
    for (int i = 0; i < WORD_W; i++) begin
      case ({b[i], prev})
        2'b01:   acc = acc + (a_ext << i);
        2'b10:   acc = acc - (a_ext << i);
        default: acc = acc;
      endcase
      prev = b[i];
    end
    mul_p = acc;
  end

`ifdef DATAPATH_DIV_EN
  word_t div_q;
  word_t div_r;

  // Signed divide, truncating toward zero; divide-by-zero gives all-ones / dividend
  always_comb begin
    div_q = '1;
    div_r = a;
    if (b != '0) begin
      div_q = word_t'($signed(a) / $signed(b));
      div_r = word_t'($signed(a) % $signed(b));
    end
  end
`endif

  // Operation select; divide overrides alu_op
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (alu_div) begin
`ifdef DATAPATH_DIV_EN
      res_hi = div_r;
      res_lo = div_q;
`endif
    end else begin
      case (alu_op)
        ALU_ADD:  res_lo = a + b;
        ALU_SUB:  res_lo = a - b;
        ALU_AND:  res_lo = a & b;
        ALU_OR:   res_lo = a | b;
        ALU_SHR:  res_lo = a >> sh;
        ALU_SHRA: res_lo = word_t'($signed(a) >>> sh);
        ALU_SHL:  res_lo = a << sh;
        ALU_ROR:  res_lo = ror_w[WORD_W-1:0];
        ALU_ROL:  res_lo = rol_w[DWORD_W-1:WORD_W];
        ALU_NEG:  res_lo = word_t'(0) - b;
        ALU_NOT:  res_lo = ~b;
        ALU_MUL:  {res_hi, res_lo} = mul_p;
        ALU_INC:  res_lo = b + word_t'(1);
        default:  res_lo = '0;
      endcase
    end
  end

  assign result_c = {res_hi, res_lo};

endmodule

// File: rtl/datapath_core.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU.
// Build option: DATAPATH_DIV_EN enables the ALU divider.
module datapath_core
  import datapath_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic [WORD_W-1:0]   A,
  input  logic [WORD_W-1:0]   RegisterImmediate,
  input  logic                Read,
  input  logic [WORD_W-1:0]   Mdatain,
  input  logic [ALUOP_W-1:0]  ALUop,
  input  logic                ALU_DIV,
  input  logic [NUM_REGS-1:0] Rin,
  input  logic [NUM_REGS-1:0] Rout,
  input  logic                MARin,
  input  logic                PCin,
  input  logic                IRin,
  input  logic                Yin,
  input  logic                MDRin,
  input  logic                HIin,
  input  logic                LOin,
  input  logic                Zhighin,
  input  logic                Zlowin,
  input  logic                MARout,
  input  logic                PCout,
  input  logic                IRout,
  input  logic                Yout,
  input  logic                MDRout,
  input  logic                HIout,
  input  logic                LOout,
  input  logic                Zhighout,
  input  logic                Zlowout,
  output logic [WORD_W-1:0]   BusMuxOut
);

  word_t  r [NUM_REGS];
  word_t  pc, ir, mar, mdr, y, hi, lo, zhigh, zlow;
  word_t  bus;
  dword_t alu_c;
  logic   unused_inputs;

  // Reserved inputs have no function in this revision
  assign unused_inputs = ^{A, RegisterImmediate};

  // Bus mux: assigned lowest priority first so the highest-priority driver wins
  always_comb begin
    bus = '0;
    if (Yout)     bus = y;
    if (IRout)    bus = ir;
    if (MARout)   bus = mar;
    if (MDRout)   bus = mdr;
    if (PCout)    bus = pc;
    if (Zlowout)  bus = zlow;
    if (Zhighout) bus = zhigh;
    if (LOout)    bus = lo;
    if (HIout)    bus = hi;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (Rout[i]) bus = r[i];
    end
  end

  assign BusMuxOut = bus;

  alu u_alu (
    .a        (y),
    .b        (bus),
    .alu_op   (ALUop),
    .alu_div  (ALU_DIV),
    .result_c (alu_c)
  );

  // Register loads; clear overrides every enable
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
      pc    <= '0;
      ir    <= '0;
      mar   <= '0;
      mdr   <= '0;
      y     <= '0;
      hi    <= '0;
      lo    <= '0;
      zhigh <= '0;
      zlow  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (Rin[i]) r[i] <= bus;
      end
      if (PCin)    pc    <= bus;
      if (IRin)    ir    <= bus;
      if (MARin)   mar   <= bus;
      if (MDRin)   mdr   <= Read ? Mdatain : bus;
      if (Yin)     y     <= bus;
      if (HIin)    hi    <= bus;
      if (LOin)    lo    <= bus;
      if (Zhighin) zhigh <= alu_c[DWORD_W-1:WORD_W];
      if (Zlowin)  zlow  <= alu_c[WORD_W-1:0];
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed scenarios plus random
// control sequences compared against a behavioural model.
module tb_datapath_core;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] A, RegisterImmediate, Mdatain;
  logic        Read, ALU_DIV;
  logic [3:0]  ALUop;
  logic [15:0] Rin, Rout;
  logic MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin;
  logic MARout, PCout, IRout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout;
  logic [31:0] BusMuxOut;

  int errors = 0;
  int checks = 0;

  // Model state; index k: 0..15 R, 16 HI, 17 LO, 18 Zhigh, 19 Zlow,
  // 20 PC, 21 MDR, 22 MAR, 23 IR, 24 Y (also the bus priority order)
  logic [31:0] m_reg [25];

  datapath_core dut (
    .clock(clock), .clear(clear), .A(A), .RegisterImmediate(RegisterImmediate),
    .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop), .ALU_DIV(ALU_DIV),
    .Rin(Rin), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .MARout(MARout), .PCout(PCout), .IRout(IRout), .Yout(Yout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .BusMuxOut(BusMuxOut)
  );

  always #5 clock = ~clock;

  function automatic logic out_en(int k);
    case (k)
      16: return HIout;    17: return LOout;  18: return Zhighout; 19: return Zlowout;
      20: return PCout;    21: return MDRout; 22: return MARout;   23: return IRout;
      24: return Yout;
      default: return Rout[k];
    endcase
  endfunction

  function automatic logic in_en(int k);
    case (k)
      16: return HIin;  17: return LOin;  18: return Zhighin; 19: return Zlowin;
      20: return PCin;  21: return MDRin; 22: return MARin;   23: return IRin;
      24: return Yin;
      default: return Rin[k];
    endcase
  endfunction

  // First asserted source in priority order drives the bus
  function automatic logic [31:0] model_bus();
    for (int k = 0; k < 25; k++) if (out_en(k)) return m_reg[k];
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(logic [31:0] a, logic [31:0] b,
                                            logic [3:0] op, logic dv);
    logic signed [31:0] sa, sb;
    longint p;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]);
    if (dv) begin
`ifdef DATAPATH_DIV_EN
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      return {32'(sa % sb), 32'(sa / sb)};
`else
      return 64'h0;
`endif
    end
    case (op)
      4'd0:  return {32'h0, 32'(a + b)};
      4'd1:  return {32'h0, 32'(a - b)};
      4'd2:  return {32'h0, a & b};
      4'd3:  return {32'h0, a | b};
      4'd4:  return {32'h0, a >> sh};
      4'd5:  return {32'h0, 32'(sa >>> sh)};
      4'd6:  return {32'h0, 32'(a << sh)};
      4'd7:  return {32'h0, (sh == 0) ? a : 32'((a >> sh) | (a << (32 - sh)))};
      4'd8:  return {32'h0, (sh == 0) ? a : 32'((a << sh) | (a >> (32 - sh)))};
      4'd9:  return {32'h0, 32'(-sb)};
      4'd10: return {32'h0, ~b};
      4'd11: begin p = longint'(sa) * longint'(sb); return 64'(p); end
      4'd12: return {32'h0, 32'(b + 1)};
      default: return 64'h0;
    endcase
  endfunction

  task automatic ctrl_idle();
    clear = 0; Read = 0; ALU_DIV = 0; ALUop = 4'd0; Mdatain = 32'h0;
    Rin = 16'h0; Rout = 16'h0;
    {MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin} = '0;
    {MARout, PCout, IRout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout} = '0;
  endtask

  task automatic drive_out(int k);
    case (k)
      16: HIout = 1;   17: LOout = 1;  18: Zhighout = 1; 19: Zlowout = 1;
      20: PCout = 1;   21: MDRout = 1; 22: MARout = 1;   23: IRout = 1;
      24: Yout = 1;
      default: Rout[k] = 1'b1;
    endcase
  endtask

  task automatic set_in(int k);
    case (k)
      16: HIin = 1;  17: LOin = 1;  18: Zhighin = 1; 19: Zlowin = 1;
      20: PCin = 1;  21: MDRin = 1; 22: MARin = 1;   23: IRin = 1;
      24: Yin = 1;
      default: Rin[k] = 1'b1;
    endcase
  endtask

  // One clock: model updates with the pre-edge bus, then controls return idle
  task automatic tick();
    logic [31:0] b;
    logic [63:0] c;
    b = model_bus();
    c = model_alu(m_reg[24], b, ALUop, ALU_DIV);
    @(posedge clock);
    if (clear) begin
      for (int k = 0; k < 25; k++) m_reg[k] = 32'h0;
    end else begin
      for (int k = 0; k < 25; k++) begin
        if (in_en(k)) begin
          if (k == 18)                m_reg[k] = c[63:32];
          else if (k == 19)           m_reg[k] = c[31:0];
          else if (k == 21 && Read)   m_reg[k] = Mdatain;
          else                        m_reg[k] = b;
        end
      end
    end
    @(negedge clock);
    ctrl_idle();
  endtask

  // Load a register through MDR (not for MDR itself)
  task automatic load_reg(int k, logic [31:0] val);
    Mdatain = val; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; set_in(k);
    tick();
  endtask

  task automatic test_reset();
    clear = 1; Rin = 16'hFFFF; Read = 1; Mdatain = 32'hDEAD_BEEF;
    {MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin} = '1;
    tick();
    #1;
    checks++;
    if (BusMuxOut !== 32'h0) begin
      errors++; $display("FAIL reset_idle_bus: got %h expected %h", BusMuxOut, 32'h0);
    end
    for (int k = 0; k < 25; k++) begin
      drive_out(k); #1;
      checks++;
      if (BusMuxOut !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", k, BusMuxOut, 32'h0);
      end
      ctrl_idle();
    end
  endtask

  task automatic test_load_path();
    Mdatain = 32'h1001_0000; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; Rin[3] = 1'b1; #1;
    checks++;
    if (BusMuxOut !== 32'h1001_0000) begin
      errors++; $display("FAIL load_bus: got %h expected %h", BusMuxOut, 32'h1001_0000);
    end
    tick();
    drive_out(3); #1;
    checks++;
    if (BusMuxOut !== 32'h1001_0000) begin
      errors++; $display("FAIL load_r3: got %h expected %h", BusMuxOut, 32'h1001_0000);
    end
    ctrl_idle();
  endtask

  task automatic test_multiply();
    load_reg(24, 32'h1001_0000);
    load_reg(1, 32'h0001_0001);
    Rout[1] = 1'b1; ALUop = 4'd11; Zlowin = 1; Zhighin = 1;
    tick();
    Zlowout = 1; LOin = 1;
    tick();
    Zhighout = 1; HIin = 1;
    tick();
    drive_out(17); #1;
    checks++;
    if (BusMuxOut !== 32'h1001_0000) begin
      errors++; $display("FAIL mul_lo: got %h expected %h", BusMuxOut, 32'h1001_0000);
    end
    ctrl_idle();
    drive_out(16); #1;
    checks++;
    if (BusMuxOut !== 32'h0000_1001) begin
      errors++; $display("FAIL mul_hi: got %h expected %h", BusMuxOut, 32'h0000_1001);
    end
    ctrl_idle();
    load_reg(24, 32'hFFFF_FFFF);
    load_reg(4, 32'd5);
    Rout[4] = 1'b1; ALUop = 4'd11; Zlowin = 1; Zhighin = 1;
    tick();
    drive_out(18); #1;
    checks++;
    if (BusMuxOut !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL smul_zhigh: got %h expected %h", BusMuxOut, 32'hFFFF_FFFF);
    end
    ctrl_idle();
    drive_out(19); #1;
    checks++;
    if (BusMuxOut !== 32'hFFFF_FFFB) begin
      errors++; $display("FAIL smul_zlow: got %h expected %h", BusMuxOut, 32'hFFFF_FFFB);
    end
    ctrl_idle();
  endtask

  task automatic test_fetch();
    load_reg(20, 32'h0);
    PCout = 1; MARin = 1; ALUop = 4'd12; Zlowin = 1;
    tick();
    Zlowout = 1; PCin = 1;
    tick();
    Read = 1; MDRin = 1; Mdatain = 32'hA5A5_A5A5;
    tick();
    MDRout = 1; IRin = 1;
    tick();
    drive_out(22); #1;
    checks++;
    if (BusMuxOut !== 32'h0) begin
      errors++; $display("FAIL fetch_mar: got %h expected %h", BusMuxOut, 32'h0);
    end
    ctrl_idle();
    drive_out(20); #1;
    checks++;
    if (BusMuxOut !== 32'h1) begin
      errors++; $display("FAIL fetch_pc: got %h expected %h", BusMuxOut, 32'h1);
    end
    ctrl_idle();
    drive_out(23); #1;
    checks++;
    if (BusMuxOut !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL fetch_ir: got %h expected %h", BusMuxOut, 32'hA5A5_A5A5);
    end
    ctrl_idle();
  endtask

  task automatic test_divide();
    logic [31:0] exp_lo [2];
    logic [31:0] exp_hi [2];
`ifdef DATAPATH_DIV_EN
    exp_lo[0] = 32'hFFFF_FFFD; exp_hi[0] = 32'hFFFF_FFFF;
    exp_lo[1] = 32'hFFFF_FFFF; exp_hi[1] = 32'hFFFF_FFF9;
`else
    exp_lo[0] = 32'h0; exp_hi[0] = 32'h0;
    exp_lo[1] = 32'h0; exp_hi[1] = 32'h0;
`endif
    load_reg(24, 32'hFFFF_FFF9);
    load_reg(6, 32'd2);
    load_reg(7, 32'd0);
    for (int t = 0; t < 2; t++) begin
      Rout[6 + t] = 1'b1; ALU_DIV = 1; ALUop = 4'd0; Zlowin = 1; Zhighin = 1;
      tick();
      drive_out(19); #1;
      checks++;
      if (BusMuxOut !== exp_lo[t]) begin
        errors++; $display("FAIL div%0d_zlow: got %h expected %h", t, BusMuxOut, exp_lo[t]);
      end
      ctrl_idle();
      drive_out(18); #1;
      checks++;
      if (BusMuxOut !== exp_hi[t]) begin
        errors++; $display("FAIL div%0d_zhigh: got %h expected %h", t, BusMuxOut, exp_hi[t]);
      end
      ctrl_idle();
    end
  endtask

  task automatic test_reset_mid_op();
    load_reg(2, 32'h2222_0002);
    load_reg(5, 32'h5555_0005);
    load_reg(3, 32'h3333_0003);
    Rout[2] = 1'b1; Rout[5] = 1'b1; #1;
    checks++;
    if (BusMuxOut !== 32'h2222_0002) begin
      errors++; $display("FAIL prio_r2_r5: got %h expected %h", BusMuxOut, 32'h2222_0002);
    end
    Rin[3] = 1'b1; clear = 1;
    tick();
    drive_out(3); #1;
    checks++;
    if (BusMuxOut !== 32'h0) begin
      errors++; $display("FAIL clear_r3: got %h expected %h", BusMuxOut, 32'h0);
    end
    ctrl_idle();
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 600; n++) begin
      clear   = ($urandom_range(0, 59) == 0);
      Read    = $urandom_range(0, 1) == 1;
      Mdatain = $urandom;
      A = $urandom; RegisterImmediate = $urandom;
      ALUop   = 4'($urandom_range(0, 15));
      ALU_DIV = ($urandom_range(0, 5) == 0);
      Rin     = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0;
      Rout    = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      {MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin} = 9'($urandom & $urandom);
      {MARout, PCout, IRout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout} =
        9'($urandom & $urandom & $urandom);
      #1;
      exp = model_bus();
      checks++;
      if (BusMuxOut !== exp) begin
        errors++; $display("FAIL rand_bus cycle %0d: got %h expected %h", n, BusMuxOut, exp);
      end
      tick();
    end
    for (int k = 0; k < 25; k++) begin
      drive_out(k); #1;
      checks++;
      if (BusMuxOut !== m_reg[k]) begin
        errors++; $display("FAIL rand_final_reg%0d: got %h expected %h", k, BusMuxOut, m_reg[k]);
      end
      ctrl_idle();
    end
  endtask

  initial begin
    A = 32'h0; RegisterImmediate = 32'h0;
    for (int k = 0; k < 25; k++) m_reg[k] = 32'h0;
    ctrl_idle();
    test_reset();
    test_load_path();
    test_multiply();
    test_fetch();
    test_divide();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
